// File: rtl/cpri_pkg_defs.sv
// Shared definitions for the CPRI transmit framer: packet type codes,
// payload-length table, header length and FSM state encoding.
package cpri_pkg_defs;

   localparam logic [3:0] TYPE_POWER = 4'd1;
   localparam logic [3:0] TYPE_DATA  = 4'd2;
   localparam logic [3:0] TYPE_BF12  = 4'd3;
   localparam logic [3:0] TYPE_BF6   = 4'd4;

   localparam int unsigned HDR_LEN = 6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_HDR,
      ST_PLD
   } state_t;

   // Payload beats per packet type; zero marks an unsupported type.
   function automatic logic [7:0] pld_len(input logic [3:0] data_type);
      case (data_type)
         TYPE_POWER: pld_len = 8'd50;
         TYPE_DATA:  pld_len = 8'd32;
         TYPE_BF12:  pld_len = 8'd80;
         TYPE_BF6:   pld_len = 8'd56;
         default:    pld_len = 8'd0;
      endcase
   endfunction

endpackage

// File: rtl/cpri_tx_framer.sv
// CPRI transmit framer: prefixes each payload packet with a 6-beat header
// once downstream credit is available, with sticky type/overlap error flags.
module cpri_tx_framer
   import cpri_pkg_defs::*;
#(
   parameter logic [63:0] SYNC_WORD = 64'hA5A5_5A5A_0F0F_F0F0,
   parameter int unsigned SEQ_WIDTH = 16
) (
   input  logic        wr_clk,
   input  logic        wr_rst,
   input  logic        i_start,
   input  logic [3:0]  i_data_type,
   input  logic [7:0]  i_slot_idx,
   input  logic [3:0]  i_sym_idx,
   input  logic        i_pld_vld,
   input  logic [63:0] i_pld_data,
   output logic        o_pld_rdy,
   input  logic [3:0]  i_free_size,
   output logic        o_vld,
   output logic        o_sop,
   output logic        o_eop,
   output logic [63:0] o_data,
   output logic        o_busy,
   output logic        o_err_type,
   output logic        o_err_ovl
);

   state_t               state;
   logic [3:0]           typ_q;
   logic [7:0]           slot_q;
   logic [3:0]           sym_q;
   logic [2:0]           beat_cnt;
   logic [7:0]           pld_cnt;
   logic [SEQ_WIDTH-1:0] seq;
   logic [63:0]          hdr_word;

   always_comb begin
      hdr_word = '0;
      case (beat_cnt)
         3'd0:    hdr_word = SYNC_WORD;
         3'd1:    hdr_word = 64'(seq);
         3'd2:    hdr_word = {48'h0, pld_len(typ_q), typ_q, 4'h0};
         3'd3:    hdr_word = {56'h0, slot_q};
         3'd4:    hdr_word = {60'h0, sym_q};
         default: hdr_word = '0;
      endcase
   end

   always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
         state      <= ST_IDLE;
         typ_q      <= '0;
         slot_q     <= '0;
         sym_q      <= '0;
         beat_cnt   <= '0;
         pld_cnt    <= '0;
         seq        <= '0;
         o_pld_rdy  <= 1'b0;
         o_vld      <= 1'b0;
         o_sop      <= 1'b0;
         o_eop      <= 1'b0;
         o_data     <= '0;
         o_busy     <= 1'b0;
         o_err_type <= 1'b0;
         o_err_ovl  <= 1'b0;
      end else begin
         o_vld  <= 1'b0;
         o_sop  <= 1'b0;
         o_eop  <= 1'b0;
         o_data <= '0;

         // The eop cycle is still owned by the finishing packet.
         if (i_start && (state != ST_IDLE || o_eop))
            o_err_ovl <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (i_start && !o_eop) begin
                  if (pld_len(i_data_type) != 8'd0) begin
                     typ_q    <= i_data_type;
                     slot_q   <= i_slot_idx;
                     sym_q    <= i_sym_idx;
                     beat_cnt <= '0;
                     o_busy   <= 1'b1;
                     state    <= ST_WAIT;
                  end else begin
                     o_err_type <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (i_free_size != '0) begin
                  o_vld    <= 1'b1;
                  o_sop    <= 1'b1;
                  o_data   <= hdr_word;
                  beat_cnt <= 3'd1;
                  state    <= ST_HDR;
               end
            end
            ST_HDR: begin
               o_vld  <= 1'b1;
               o_data <= hdr_word;
               if (beat_cnt == 3'(HDR_LEN - 1)) begin
                  pld_cnt   <= '0;
                  o_pld_rdy <= 1'b1;
                  state     <= ST_PLD;
               end else begin
                  beat_cnt <= beat_cnt + 3'd1;
               end
            end
            ST_PLD: begin
               if (i_pld_vld && o_pld_rdy) begin
                  o_vld  <= 1'b1;
                  o_data <= i_pld_data;
                  if (pld_cnt == pld_len(typ_q) - 8'd1) begin
                     o_eop     <= 1'b1;
                     o_pld_rdy <= 1'b0;
                     o_busy    <= 1'b0;
                     seq       <= seq + 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     pld_cnt <= pld_cnt + 8'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/cpri_tx_framer.md
CPRI_TX_FRAMER -- requirements
Module: cpri_tx_framer

Interface
REQ-001 Parameter SYNC_WORD, default 64'hA5A5_5A5A_0F0F_F0F0, constant written to header beat 0.
REQ-002 Parameter SEQ_WIDTH, default 16, width of the packet sequence counter.
REQ-003 wr_clk  input  1  sole clock; all logic rises on it.
REQ-004 wr_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_start  input  1  one-cycle request to frame one packet.
REQ-006 i_data_type  input  4  packet type, sampled with i_start: 1 power, 2 data, 3 data+bf-12RB, 4 data+bf-6RB.
REQ-007 i_slot_idx  input  8  slot index, sampled with i_start.
REQ-008 i_sym_idx  input  4  symbol index, sampled with i_start.
REQ-009 i_pld_vld  input  1  payload beat valid.
REQ-010 i_pld_data  input  64  payload beat.
REQ-011 o_pld_rdy  output  1  payload beat accepted when i_pld_vld&o_pld_rdy.
REQ-012 i_free_size  input  4  downstream packet-slot credit, already synchronised to wr_clk.
REQ-013 o_vld, o_sop, o_eop  output  1 each  output beat qualifiers.
REQ-014 o_data  output  64  output beat.
REQ-015 o_busy  output  1  high in any state other than IDLE.
REQ-016 o_err_type, o_err_ovl  output  1 each  sticky error flags.

Function
REQ-017 FSM states: IDLE, WAIT, HDR, PLD; next state decided from registered state only.
REQ-018 IDLE: i_start with type 1..4 latches type/slot/sym -> WAIT; i_start with other type sets o_err_type and stays IDLE.
REQ-019 WAIT: i_free_size != 0 -> HDR; else hold.
REQ-020 HDR: emit 6 beats on consecutive cycles, beat counter 0..5, o_pld_rdy=0; beat 0 with o_sop=1.
REQ-021 Header beat 0 = SYNC_WORD; beat 1 = zero-extended sequence number; beat 2 = {48'h0, 8'd payload_len, type[3:0], 4'h0}; beat 3 = {56'h0, slot}; beat 4 = {60'h0, sym}; beat 5 = 64'h0.
REQ-022 Payload length N by type: 1 -> 50, 2 -> 32, 3 -> 80, 4 -> 56 (total beats 56/38/86/62).
REQ-023 PLD: o_pld_rdy=1; each accepted beat appears on o_data with o_vld=1 exactly one cycle later; no o_vld when i_pld_vld=0 (gaps allowed, packet not aborted).
REQ-024 N-th accepted payload beat carries o_eop=1; o_pld_rdy drops the same cycle it is accepted; FSM -> IDLE.
REQ-025 All outputs registered; o_data=0 whenever o_vld=0.
REQ-026 Sequence counter increments by 1 on each o_eop, wraps 2^SEQ_WIDTH-1 -> 0.
REQ-027 i_start while not IDLE: ignored, sets o_err_ovl; i_start coincident with o_eop cycle also counts as overlap.
REQ-028 Back-to-back: earliest next o_sop is 2 cycles after o_eop (IDLE, WAIT).
REQ-029 Payload beats are never accepted outside PLD.

Reset
REQ-030 wr_rst asserted: FSM IDLE, counters 0, sequence 0, all outputs 0, error flags cleared, immediately and independent of clock.
REQ-031 Reset mid-packet truncates the packet with no o_eop; first packet after release starts with sequence 0.

Structure
REQ-032 Shared package cpri_pkg_defs holds type codes, payload-length table, header length 6, FSM state encoding.
REQ-033 Single flat module; no sub-module required.

Verification
REQ-034 type 2, slot 8'h12, sym 4'h3, free_size 4, payload always valid -> 38 beats contiguous, sop beat0 = SYNC_WORD, beat2[7:4]=2, beat2[15:8]=32, eop on beat 37, seq 0.
REQ-035 type 3 with i_pld_vld toggling 1/0 -> exactly 86 o_vld beats, payload order preserved, o_eop only on 86th.
REQ-036 free_size 0 for 20 cycles then 1 -> o_busy high, no o_vld until 1 cycle after free_size nonzero.
REQ-037 i_start type 7 -> o_err_type=1, no output; i_start during PLD -> o_err_ovl=1, current packet intact.
REQ-038 65536+1 back-to-back type 1 packets -> beat 1 of last packet = 0 (wrap), sop spacing = 58 cycles.
REQ-039 wr_rst pulse at payload beat 10 of type 4 -> all outputs 0 same cycle, next packet seq 0, full 62 beats.
